// File: rtl/riscv_defs_pkg.sv
// riscv_defs_pkg: shared RV32I decode definitions.
//   - opcode / funct3 / funct7 constants
//   - AluOp (sub-operation) and AluSel (result class) encodings, both with NOP = 0
//   - ZeroWord, NopRegAddr
//   - operand-select and immediate-format enums, plus an immediate generator
package riscv_defs_pkg;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3SrlSra = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    localparam int unsigned AluOpW  = 8;
    localparam int unsigned AluSelW = 3;

    localparam logic [AluOpW-1:0] AluOpNop  = 8'd0;
    localparam logic [AluOpW-1:0] AluOpAdd  = 8'd1;
    localparam logic [AluOpW-1:0] AluOpSub  = 8'd2;
    localparam logic [AluOpW-1:0] AluOpSll  = 8'd3;
    localparam logic [AluOpW-1:0] AluOpSlt  = 8'd4;
    localparam logic [AluOpW-1:0] AluOpSltu = 8'd5;
    localparam logic [AluOpW-1:0] AluOpXor  = 8'd6;
    localparam logic [AluOpW-1:0] AluOpSrl  = 8'd7;
    localparam logic [AluOpW-1:0] AluOpSra  = 8'd8;
    localparam logic [AluOpW-1:0] AluOpOr   = 8'd9;
    localparam logic [AluOpW-1:0] AluOpAnd  = 8'd10;
    localparam logic [AluOpW-1:0] AluOpJal  = 8'd11;
    localparam logic [AluOpW-1:0] AluOpJalr = 8'd12;
    // Branch ops are AluOpBeq + funct3; load/store ops are base + funct3.
    localparam logic [AluOpW-1:0] AluOpBeq  = 8'd16;
    localparam logic [AluOpW-1:0] AluOpLb   = 8'd24;
    localparam logic [AluOpW-1:0] AluOpSb   = 8'd32;

    localparam logic [AluSelW-1:0] AluSelNop   = 3'd0;
    localparam logic [AluSelW-1:0] AluSelArith = 3'd1;
    localparam logic [AluSelW-1:0] AluSelLogic = 3'd2;
    localparam logic [AluSelW-1:0] AluSelShift = 3'd3;
    localparam logic [AluSelW-1:0] AluSelJump  = 3'd4;
    localparam logic [AluSelW-1:0] AluSelMem   = 3'd5;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NopRegAddr = 5'd0;

    typedef enum logic [1:0] {Op1Zero, Op1Pc, Op1Rs1} op1_sel_e;
    typedef enum logic       {Op2Imm, Op2Rs2}         op2_sel_e;
    typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

    function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            ImmS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            ImmB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            ImmU:    imm = {inst[31:12], 12'b0};
            ImmJ:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = {{20{inst[31]}}, inst[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: ID -> EX bundle (valid/ready handshake plus the registered decode result).
//   master: driven by id_stage (everything except out_ready)
//   slave : the execute stage (drives out_ready)
interface id_stage_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUOP_W    = 8,
    parameter int unsigned ALUSEL_W   = 3
) ();
    logic                  out_valid;
    logic                  out_ready;
    logic [ALUOP_W-1:0]    aluop;
    logic [ALUSEL_W-1:0]   alusel;
    logic [XLEN-1:0]       reg1;
    logic [XLEN-1:0]       reg2;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic                  is_load;
    logic                  is_store;
    logic                  is_branch;
    logic                  is_jump;
    logic                  illegal;

    modport master (
        output out_valid, aluop, alusel, reg1, reg2, imm, pc, wd, wreg,
               is_load, is_store, is_branch, is_jump, illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, aluop, alusel, reg1, reg2, imm, pc, wd, wreg,
               is_load, is_store, is_branch, is_jump, illegal,
        output out_ready
    );
endinterface

// File: rtl/id_decode_core.sv
// id_decode_core: purely combinational RV32I decoder.
//   inst_i        instruction word
//   aluop_o/alusel_o, op1_sel_o/op2_sel_o, imm_o (sign-extended), wd_o/wreg_o,
//   reg*_read_o/reg*_addr_o, is_load/store/branch/jump_o, illegal_o
// Illegal instructions decode to a NOP with no reads and no write-back.
module id_decode_core
    import riscv_defs_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUOP_W    = 8,
    parameter int unsigned ALUSEL_W   = 3
) (
    input  logic [31:0]           inst_i,
    output logic [ALUOP_W-1:0]    aluop_o,
    output logic [ALUSEL_W-1:0]   alusel_o,
    output op1_sel_e              op1_sel_o,
    output op2_sel_e              op2_sel_o,
    output logic [XLEN-1:0]       imm_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic                  reg1_read_o,
    output logic                  reg2_read_o,
    output logic [REG_ADDR_W-1:0] reg1_addr_o,
    output logic [REG_ADDR_W-1:0] reg2_addr_o,
    output logic                  is_load_o,
    output logic                  is_store_o,
    output logic                  is_branch_o,
    output logic                  is_jump_o,
    output logic                  illegal_o
);
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic       is_op, alt, f7_ok;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign funct7 = inst_i[31:25];
    assign is_op  = (opcode == OpcOp);
    assign alt    = (funct7 == F7Alt);
    assign f7_ok  = (funct7 == F7Base) || alt;

    logic [AluOpW-1:0]  aluop;
    logic [AluSelW-1:0] alusel;
    imm_fmt_e           fmt;
    logic               wr, rd1, rd2, ld, st, br, jmp, ill;

    always_comb begin
        aluop = AluOpNop;  alusel = AluSelNop;
        op1_sel_o = Op1Zero; op2_sel_o = Op2Imm; fmt = ImmI;
        wr = 1'b0; rd1 = 1'b0; rd2 = 1'b0;
        ld = 1'b0; st = 1'b0; br = 1'b0; jmp = 1'b0; ill = 1'b0;
        case (opcode)
            OpcLui: begin
                aluop = AluOpAdd; alusel = AluSelArith; fmt = ImmU; wr = 1'b1;
            end
            OpcAuipc: begin
                aluop = AluOpAdd; alusel = AluSelArith; fmt = ImmU; wr = 1'b1;
                op1_sel_o = Op1Pc;
            end
            OpcJal: begin
                aluop = AluOpJal; alusel = AluSelJump; fmt = ImmJ; wr = 1'b1; jmp = 1'b1;
                op1_sel_o = Op1Pc;
            end
            OpcJalr: begin
                aluop = AluOpJalr; alusel = AluSelJump; wr = 1'b1; jmp = 1'b1;
                op1_sel_o = Op1Rs1; rd1 = 1'b1;
                ill = (funct3 != 3'b000);
            end
            OpcBranch: begin
                aluop = AluOpBeq + AluOpW'(funct3); alusel = AluSelJump; fmt = ImmB; br = 1'b1;
                op1_sel_o = Op1Rs1; op2_sel_o = Op2Rs2; rd1 = 1'b1; rd2 = 1'b1;
                ill = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OpcLoad: begin
                aluop = AluOpLb + AluOpW'(funct3); alusel = AluSelMem; wr = 1'b1; ld = 1'b1;
                op1_sel_o = Op1Rs1; rd1 = 1'b1;
                ill = (funct3 == 3'b011) || funct3[2:1] == 2'b11;
            end
            OpcStore: begin
                aluop = AluOpSb + AluOpW'(funct3); alusel = AluSelMem; fmt = ImmS; st = 1'b1;
                op1_sel_o = Op1Rs1; op2_sel_o = Op2Rs2; rd1 = 1'b1; rd2 = 1'b1;
                ill = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OpcOpImm, OpcOp: begin
                op1_sel_o = Op1Rs1; rd1 = 1'b1; wr = 1'b1;
                if (is_op) begin
                    op2_sel_o = Op2Rs2; rd2 = 1'b1;
                end
                // OP-IMM only constrains funct7 for shifts; OP constrains it everywhere.
                case (funct3)
                    F3AddSub: begin
                        alusel = AluSelArith; aluop = (is_op && alt) ? AluOpSub : AluOpAdd;
                        ill = is_op && !f7_ok;
                    end
                    F3Sll: begin
                        alusel = AluSelShift; aluop = AluOpSll; ill = (funct7 != F7Base);
                    end
                    F3Slt: begin
                        alusel = AluSelArith; aluop = AluOpSlt; ill = is_op && (funct7 != F7Base);
                    end
                    F3Sltu: begin
                        alusel = AluSelArith; aluop = AluOpSltu; ill = is_op && (funct7 != F7Base);
                    end
                    F3Xor: begin
                        alusel = AluSelLogic; aluop = AluOpXor; ill = is_op && (funct7 != F7Base);
                    end
                    F3SrlSra: begin
                        alusel = AluSelShift; aluop = alt ? AluOpSra : AluOpSrl; ill = !f7_ok;
                    end
                    F3Or: begin
                        alusel = AluSelLogic; aluop = AluOpOr; ill = is_op && (funct7 != F7Base);
                    end
                    F3And: begin
                        alusel = AluSelLogic; aluop = AluOpAnd; ill = is_op && (funct7 != F7Base);
                    end
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            aluop = AluOpNop; alusel = AluSelNop;
            op1_sel_o = Op1Zero; op2_sel_o = Op2Imm;
            wr = 1'b0; rd1 = 1'b0; rd2 = 1'b0;
            ld = 1'b0; st = 1'b0; br = 1'b0; jmp = 1'b0;
        end
    end

    assign aluop_o     = ALUOP_W'(aluop);
    assign alusel_o    = ALUSEL_W'(alusel);
    assign imm_o       = XLEN'($signed(gen_imm(inst_i, fmt)));
    assign wreg_o      = wr && (rd != 5'd0);
    assign wd_o        = wr ? REG_ADDR_W'(rd) : REG_ADDR_W'(NopRegAddr);
    assign reg1_read_o = rd1;
    assign reg2_read_o = rd2;
    assign reg1_addr_o = rd1 ? REG_ADDR_W'(rs1) : REG_ADDR_W'(NopRegAddr);
    assign reg2_addr_o = rd2 ? REG_ADDR_W'(rs2) : REG_ADDR_W'(NopRegAddr);
    assign is_load_o   = ld;
    assign is_store_o  = st;
    assign is_branch_o = br;
    assign is_jump_o   = jmp;
    assign illegal_o   = ill;
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with integrated ID/EX pipeline register.
//   clk, rst (synchronous, active-low)
//   fetch side : in_valid_i/in_ready_o, pc_i, inst_i
//   regfile    : reg*_read_o, reg*_addr_o (combinational), reg*_data_i
//   bypass     : ex_wreg_i/ex_wd_i/ex_wdata_i/ex_is_load_i, mem_wreg_i/mem_wd_i/mem_wdata_i
//   flush_i    : drop held and incoming instruction
//   ex_if      : id_stage_if.master, registered decode result with out_valid/out_ready
// Build option: define ID_FORWARD_EN for EX/MEM forwarding (stall only on load-use);
// otherwise any pending EX/MEM writer of a source register stalls the stage.
module id_stage
    import riscv_defs_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUOP_W    = 8,
    parameter int unsigned ALUSEL_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [31:0]           inst_i,
    output logic                  reg1_read_o,
    output logic                  reg2_read_o,
    output logic [REG_ADDR_W-1:0] reg1_addr_o,
    output logic [REG_ADDR_W-1:0] reg2_addr_o,
    input  logic [XLEN-1:0]       reg1_data_i,
    input  logic [XLEN-1:0]       reg2_data_i,
    input  logic                  ex_wreg_i,
    input  logic [REG_ADDR_W-1:0] ex_wd_i,
    input  logic [XLEN-1:0]       ex_wdata_i,
    input  logic                  ex_is_load_i,
    input  logic                  mem_wreg_i,
    input  logic [REG_ADDR_W-1:0] mem_wd_i,
    input  logic [XLEN-1:0]       mem_wdata_i,
    input  logic                  flush_i,
    id_stage_if.master            ex_if
);
    typedef struct packed {
        logic                  valid;
        logic [ALUOP_W-1:0]    aluop;
        logic [ALUSEL_W-1:0]   alusel;
        logic [XLEN-1:0]       reg1;
        logic [XLEN-1:0]       reg2;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic                  is_load;
        logic                  is_store;
        logic                  is_branch;
        logic                  is_jump;
        logic                  illegal;
    } id_ex_t;

    id_ex_t id_ex_q, id_ex_d, dec;
    op1_sel_e op1_sel;
    op2_sel_e op2_sel;

    id_decode_core #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W),
        .ALUOP_W    (ALUOP_W),
        .ALUSEL_W   (ALUSEL_W)
    ) u_decode (
        .inst_i      (inst_i),
        .aluop_o     (dec.aluop),
        .alusel_o    (dec.alusel),
        .op1_sel_o   (op1_sel),
        .op2_sel_o   (op2_sel),
        .imm_o       (dec.imm),
        .wd_o        (dec.wd),
        .wreg_o      (dec.wreg),
        .reg1_read_o (reg1_read_o),
        .reg2_read_o (reg2_read_o),
        .reg1_addr_o (reg1_addr_o),
        .reg2_addr_o (reg2_addr_o),
        .is_load_o   (dec.is_load),
        .is_store_o  (dec.is_store),
        .is_branch_o (dec.is_branch),
        .is_jump_o   (dec.is_jump),
        .illegal_o   (dec.illegal)
    );

    // x0 sources are never live, so they neither forward nor hazard.
    logic rs1_live, rs2_live, ex_hit1, ex_hit2, mem_hit1, mem_hit2, hazard;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign rs1_live = reg1_read_o && (reg1_addr_o != '0);
    assign rs2_live = reg2_read_o && (reg2_addr_o != '0);
    assign ex_hit1  = rs1_live && ex_wreg_i  && (ex_wd_i  == reg1_addr_o);
    assign ex_hit2  = rs2_live && ex_wreg_i  && (ex_wd_i  == reg2_addr_o);
    assign mem_hit1 = rs1_live && mem_wreg_i && (mem_wd_i == reg1_addr_o);
    assign mem_hit2 = rs2_live && mem_wreg_i && (mem_wd_i == reg2_addr_o);

`ifdef ID_FORWARD_EN
    assign hazard  = ex_is_load_i && (ex_hit1 || ex_hit2);
    assign rs1_val = !rs1_live ? '0 : ex_hit1 ? ex_wdata_i : mem_hit1 ? mem_wdata_i : reg1_data_i;
    assign rs2_val = !rs2_live ? '0 : ex_hit2 ? ex_wdata_i : mem_hit2 ? mem_wdata_i : reg2_data_i;
`else
    logic            unused_bypass;
    logic [XLEN-1:0] unused_wdata;
    assign unused_bypass = ex_is_load_i;
    assign unused_wdata  = ex_wdata_i ^ mem_wdata_i;
    assign hazard  = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
    assign rs1_val = rs1_live ? reg1_data_i : '0;
    assign rs2_val = rs2_live ? reg2_data_i : '0;
`endif

    always_comb begin
        dec.valid = 1'b1;
        dec.pc    = pc_i;
        case (op1_sel)
            Op1Zero: dec.reg1 = XLEN'(ZeroWord);
            Op1Pc:   dec.reg1 = pc_i;
            default: dec.reg1 = rs1_val;
        endcase
        dec.reg2 = (op2_sel == Op2Rs2) ? rs2_val : dec.imm;
    end

    logic load_en, accept;
    assign load_en    = !id_ex_q.valid || ex_if.out_ready;
    assign accept     = load_en && in_valid_i && !hazard;
    assign in_ready_o = flush_i || (load_en && !hazard);

    // Bubbles load the all-zero NOP so downstream never sees stale write-back enables.
    always_comb begin
        id_ex_d = id_ex_q;
        if (flush_i) begin
            id_ex_d = '0;
        end else if (load_en) begin
            id_ex_d = accept ? dec : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ex_if.out_valid = id_ex_q.valid;
    assign ex_if.aluop     = id_ex_q.aluop;
    assign ex_if.alusel    = id_ex_q.alusel;
    assign ex_if.reg1      = id_ex_q.reg1;
    assign ex_if.reg2      = id_ex_q.reg2;
    assign ex_if.imm       = id_ex_q.imm;
    assign ex_if.pc        = id_ex_q.pc;
    assign ex_if.wd        = id_ex_q.wd;
    assign ex_if.wreg      = id_ex_q.wreg;
    assign ex_if.is_load   = id_ex_q.is_load;
    assign ex_if.is_store  = id_ex_q.is_store;
    assign ex_if.is_branch = id_ex_q.is_branch;
    assign ex_if.is_jump   = id_ex_q.is_jump;
    assign ex_if.illegal   = id_ex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector bench for id_stage; expectations follow ID_FORWARD_EN.
module tb_id_stage;
    import riscv_defs_pkg::*;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned ALUSEL_W   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, in_valid, in_ready, flush;
    logic [XLEN-1:0]       pc;
    logic [31:0]           inst;
    logic                  reg1_read, reg2_read;
    logic [REG_ADDR_W-1:0] reg1_addr, reg2_addr;
    logic [XLEN-1:0]       reg1_data, reg2_data;
    logic                  ex_wreg, ex_is_load, mem_wreg;
    logic [REG_ADDR_W-1:0] ex_wd, mem_wd;
    logic [XLEN-1:0]       ex_wdata, mem_wdata;
    logic [XLEN-1:0]       rf [32];

    id_stage_if #(
        .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)
    ) ex_if ();

    assign reg1_data = rf[reg1_addr];
    assign reg2_data = rf[reg2_addr];

    id_stage #(
        .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .pc_i         (pc),
        .inst_i       (inst),
        .reg1_read_o  (reg1_read),
        .reg2_read_o  (reg2_read),
        .reg1_addr_o  (reg1_addr),
        .reg2_addr_o  (reg2_addr),
        .reg1_data_i  (reg1_data),
        .reg2_data_i  (reg2_data),
        .ex_wreg_i    (ex_wreg),
        .ex_wd_i      (ex_wd),
        .ex_wdata_i   (ex_wdata),
        .ex_is_load_i (ex_is_load),
        .mem_wreg_i   (mem_wreg),
        .mem_wd_i     (mem_wd),
        .mem_wdata_i  (mem_wdata),
        .flush_i      (flush),
        .ex_if        (ex_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] p, input logic [31:0] i);
        in_valid = 1'b1;
        pc       = p;
        inst     = i;
        #1;
    endtask

    task automatic clear_bypass();
        ex_wreg = 1'b0; ex_wd = '0; ex_wdata = '0; ex_is_load = 1'b0;
        mem_wreg = 1'b0; mem_wd = '0; mem_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 | i;
        rf[0] = '0;
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; pc = '0; inst = 32'h0000_0013;
        ex_if.out_ready = 1'b1;
        clear_bypass();
        tick(); tick();
        check("rst_valid", ex_if.out_valid, 0);
        check("rst_aluop", ex_if.aluop, AluOpNop);
        check("rst_wd", ex_if.wd, 0);
        rst = 1'b1;

        // ADDI x1,x0,5
        issue(32'h100, 32'h0050_0093);
        check("addi_rd1_en", reg1_read, 1);
        check("addi_rs1", reg1_addr, 0);
        check("addi_rd2_en", reg2_read, 0);
        check("addi_ready", in_ready, 1);
        tick();
        check("addi_valid", ex_if.out_valid, 1);
        check("addi_reg1", ex_if.reg1, 0);
        check("addi_reg2", ex_if.reg2, 5);
        check("addi_wd", ex_if.wd, 1);
        check("addi_wreg", ex_if.wreg, 1);
        check("addi_pc", ex_if.pc, 32'h100);
        check("addi_aluop", ex_if.aluop, AluOpAdd);
        check("addi_alusel", ex_if.alusel, AluSelArith);

        // ADDI x1,x0,-1 : sign extension
        issue(32'h104, 32'hFFF0_0093); tick();
        check("neg_imm", ex_if.imm, 32'hFFFF_FFFF);
        check("neg_reg2", ex_if.reg2, 32'hFFFF_FFFF);

        // LW x5,8(x1)
        issue(32'h108, 32'h0080_A283); tick();
        check("lw_is_load", ex_if.is_load, 1);
        check("lw_reg1", ex_if.reg1, 32'hA000_0001);
        check("lw_reg2", ex_if.reg2, 8);
        check("lw_wd", ex_if.wd, 5);

        // ADD x3,x1,x2 with EX writing x1, MEM writing x2
        ex_wreg = 1'b1; ex_wd = 5'd1; ex_wdata = 32'd7;
        mem_wreg = 1'b1; mem_wd = 5'd2; mem_wdata = 32'd9;
        issue(32'h10C, 32'h0020_81B3);
`ifdef ID_FORWARD_EN
        check("fwd_ready", in_ready, 1);
        tick();
        check("fwd_reg1_ex", ex_if.reg1, 7);
        check("fwd_reg2_mem", ex_if.reg2, 9);
        check("fwd_wd", ex_if.wd, 3);
        // ADD x4,x1,x1 with both stages writing x1: EX wins
        mem_wd = 5'd1;
        issue(32'h110, 32'h0010_8233); tick();
        check("prio_reg1", ex_if.reg1, 7);
        check("prio_reg2", ex_if.reg2, 7);
`else
        check("raw_ready0", in_ready, 0);
        tick();
        check("raw_bubble0", ex_if.out_valid, 0);
        ex_wreg = 1'b0; mem_wd = 5'd1; #1;
        check("raw_ready1", in_ready, 0);
        tick();
        check("raw_bubble1", ex_if.out_valid, 0);
        mem_wreg = 1'b0; #1;
        check("raw_ready2", in_ready, 1);
        tick();
        check("raw_valid", ex_if.out_valid, 1);
        check("raw_reg1", ex_if.reg1, 32'hA000_0001);
        check("raw_reg2", ex_if.reg2, 32'hA000_0002);
        check("raw_wd", ex_if.wd, 3);
`endif
        clear_bypass();

        // ADD x5,x0,x2 with a load "writing" x0 in EX: no forward, no hazard
        ex_wreg = 1'b1; ex_wd = 5'd0; ex_wdata = 32'hDEAD; ex_is_load = 1'b1;
        issue(32'h114, 32'h0020_02B3);
        check("x0_ready", in_ready, 1);
        tick();
        check("x0_reg1", ex_if.reg1, 0);
        check("x0_reg2", ex_if.reg2, 32'hA000_0002);
        clear_bypass();

        // Load-use: LW x5 in EX, ADD x6,x5,x5 in ID
        ex_wreg = 1'b1; ex_wd = 5'd5; ex_wdata = 32'hBAD; ex_is_load = 1'b1;
        issue(32'h118, 32'h0052_8333);
        check("lu_ready", in_ready, 0);
        tick();
        check("lu_bubble", ex_if.out_valid, 0);
        check("lu_bubble_wreg", ex_if.wreg, 0);
        clear_bypass();
        mem_wreg = 1'b1; mem_wd = 5'd5; mem_wdata = 32'h55; #1;
`ifdef ID_FORWARD_EN
        check("lu_ready_after", in_ready, 1);
        tick();
        check("lu_valid", ex_if.out_valid, 1);
        check("lu_reg1", ex_if.reg1, 32'h55);
        check("lu_reg2", ex_if.reg2, 32'h55);
        check("lu_wd", ex_if.wd, 6);
`else
        check("lu_ready_mem", in_ready, 0);
        tick();
        check("lu_bubble2", ex_if.out_valid, 0);
        mem_wreg = 1'b0; #1;
        check("lu_ready_after", in_ready, 1);
        tick();
        check("lu_valid", ex_if.out_valid, 1);
        check("lu_reg1", ex_if.reg1, 32'hA000_0005);
        check("lu_wd", ex_if.wd, 6);
`endif
        clear_bypass();

        // Back-pressure: hold 3 cycles, then release
        issue(32'h11C, 32'h1230_0393); tick();
        check("bp_first", ex_if.reg2, 32'h123);
        ex_if.out_ready = 1'b0;
        issue(32'h120, 32'h0440_0413);
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", in_ready, 0);
            tick();
            check("bp_valid", ex_if.out_valid, 1);
            check("bp_reg2", ex_if.reg2, 32'h123);
            check("bp_wd", ex_if.wd, 7);
        end
        ex_if.out_ready = 1'b1; #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_next_valid", ex_if.out_valid, 1);
        check("bp_next_reg2", ex_if.reg2, 32'h44);
        check("bp_next_wd", ex_if.wd, 8);

        // Flush with a valid input
        flush = 1'b1;
        issue(32'h124, 32'h0010_0493);
        check("fl_ready", in_ready, 1);
        tick();
        check("fl_valid", ex_if.out_valid, 0);
        flush = 1'b0;

        // Flush while stalled downstream
        issue(32'h128, 32'h0010_0493); tick();
        check("fl2_pre_wd", ex_if.wd, 9);
        ex_if.out_ready = 1'b0; flush = 1'b1;
        issue(32'h12C, 32'h0020_0513);
        check("fl2_ready", in_ready, 1);
        tick();
        check("fl2_valid", ex_if.out_valid, 0);
        flush = 1'b0; ex_if.out_ready = 1'b1; in_valid = 1'b0; #1;
        tick();
        check("fl2_dropped", ex_if.out_valid, 0);

        // Illegal opcode and illegal funct7
        issue(32'h130, 32'h0000_007F); tick();
        check("ill_op_flag", ex_if.illegal, 1);
        check("ill_op_wreg", ex_if.wreg, 0);
        check("ill_op_aluop", ex_if.aluop, AluOpNop);
        check("ill_op_valid", ex_if.out_valid, 1);
        issue(32'h134, 32'h0220_81B3); tick();
        check("ill_f7_flag", ex_if.illegal, 1);
        check("ill_f7_wreg", ex_if.wreg, 0);

        // ADDI x0,x0,1
        issue(32'h138, 32'h0010_0013); tick();
        check("x0dst_wreg", ex_if.wreg, 0);
        check("x0dst_ill", ex_if.illegal, 0);

        // BEQ x1,x2,+8
        issue(32'h13C, 32'h0020_8463); tick();
        check("beq_branch", ex_if.is_branch, 1);
        check("beq_wreg", ex_if.wreg, 0);
        check("beq_imm", ex_if.imm, 8);
        check("beq_reg2", ex_if.reg2, 32'hA000_0002);

        // JAL x1,+16 at pc 0x200
        issue(32'h200, 32'h0100_00EF); tick();
        check("jal_reg1", ex_if.reg1, 32'h200);
        check("jal_reg2", ex_if.reg2, 32'h10);
        check("jal_jump", ex_if.is_jump, 1);
        check("jal_wd", ex_if.wd, 1);
        check("jal_wreg", ex_if.wreg, 1);

        // Reset while stalled drops the held instruction
        issue(32'h204, 32'h1230_0393); tick();
        ex_if.out_ready = 1'b0;
        issue(32'h208, 32'h0440_0413);
        rst = 1'b0;
        tick();
        check("mrst_valid", ex_if.out_valid, 0);
        check("mrst_reg2", ex_if.reg2, 0);
        check("mrst_wd", ex_if.wd, 0);
        check("mrst_pc", ex_if.pc, 0);
        check("mrst_aluop", ex_if.aluop, AluOpNop);
        rst = 1'b1; ex_if.out_ready = 1'b1; in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
